// File: rtl/mux_sel_pkg.sv
// mux_sel_pkg: shared constants, state encoding and channel-wrap helper for the 5-way round-robin mux select
package mux_sel_pkg;

    localparam int NUM_CH        = 5;
    localparam int SEL_W         = 3;
    localparam int TO_CYCLES_DEF = 15;

    // Reset value of the last-granted pointer so that channel 0 wins the first search
    localparam logic [SEL_W-1:0] LAST_RST = 3'd4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Next channel index in cyclic order, 4 wraps to 0
    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch);
        return (ch >= SEL_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick5.sv
// rr_pick5: combinational cyclic priority search over 5 requests, starting just after start_i
module rr_pick5
    import mux_sel_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [SEL_W-1:0]  start_i,
    output logic [SEL_W-1:0]  idx_o,
    output logic              found_o
);

    logic [SEL_W-1:0] ch;

    // Walk start+1, start+2, ... start+5 (mod 5) and keep the first set mask bit
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        ch      = start_i;
        for (int k = 0; k < NUM_CH; k++) begin
            ch = next_ch(ch);
            if (!found_o && mask_i[ch]) begin
                idx_o   = ch;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_sel_rr5.sv
// mux_sel_rr5: round-robin select generator for a 5-to-1 mux with registered S/VALID.
// Optional grant timeout enabled by defining MUX_SEL_TIMEOUT_EN (adds TIMEOUT port and counter).
module mux_sel_rr5
    import mux_sel_pkg::*;
#(
    parameter int TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_CH-1:0] REQ,
    input  logic              ACK,
    output logic [SEL_W-1:0]  S,
`ifdef MUX_SEL_TIMEOUT_EN
    output logic              TIMEOUT,
`endif
    output logic              VALID
);

    if (TO_CYCLES < 1 || TO_CYCLES > 15) begin : g_bad_to
        $error("mux_sel_rr5: TO_CYCLES must be within 1..15");
    end

    state_e           state_q, state_d;
    logic [SEL_W-1:0] s_q, s_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [NUM_CH-1:0] pick_mask;
    logic [SEL_W-1:0]  pick_start;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_found;
    logic              release_g;

`ifdef MUX_SEL_TIMEOUT_EN
    logic [3:0] cnt_q, cnt_d;
    logic       expire;

    // Expiry only counts when the downstream did not consume this cycle; ACK wins a tie
    assign expire  = (state_q == GRANT) && !ACK && (cnt_q == 4'(TO_CYCLES - 1));
    assign TIMEOUT = expire;
    assign release_g = (state_q == GRANT) && (ACK || expire);

    // Counter restarts on every new grant and advances while the grant is held
    assign cnt_d = (state_q == GRANT && !release_g) ? cnt_q + 4'd1 : 4'd0;

    // Grant-age counter register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt_q <= 4'd0;
        else     cnt_q <= cnt_d;
    end
`else
    assign release_g = (state_q == GRANT) && ACK;
`endif

    // While granted, the current channel is masked out so another requester gets the next turn
    assign pick_mask  = (state_q == GRANT) ? (REQ & ~(5'b00001 << s_q)) : REQ;
    assign pick_start = (state_q == GRANT) ? s_q : last_q;

    rr_pick5 u_pick (
        .mask_i  (pick_mask),
        .start_i (pick_start),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Next-state: arbitrate from IDLE, hold a grant until released, then hand over or drop to IDLE
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        last_d  = last_q;
        if (state_q == IDLE) begin
            state_d = pick_found ? GRANT : IDLE;
            s_d     = pick_found ? pick_idx : '0;
        end else if (release_g) begin
            last_d  = s_q;
            state_d = pick_found ? GRANT : IDLE;
            s_d     = pick_found ? pick_idx : '0;
        end
    end

    // State, select and last-granted pointer registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            s_q     <= '0;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            last_q  <= last_d;
        end
    end

    assign S     = s_q;
    assign VALID = (state_q == GRANT);

endmodule

// File: doc/mux_sel_rr5.md
MUX_SEL_RR5 -- requirements
Module: mux_sel_rr5

Interface
REQ-001 The block SHALL have parameter TO_CYCLES, default 15, the grant timeout in cycles (range 1..15); it is used only when MUX_SEL_TIMEOUT_EN is defined.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port REQ, input, 5 bits: bit n high means channel n (the n-th input of the downstream 3-bit 5-to-1 mux) has data.
REQ-005 The block SHALL have port ACK, input, 1 bit: the downstream stage consumed the selected channel this cycle.
REQ-006 The block SHALL have port S, output, 3 bits: the mux select, always 3'b000..3'b100, registered.
REQ-007 The block SHALL have port VALID, output, 1 bit: S names a granted channel, registered.
REQ-008 The block SHALL have port TIMEOUT, output, 1 bit: one-cycle pulse when a grant is abandoned; it exists only with MUX_SEL_TIMEOUT_EN.

Function
REQ-009 The FSM SHALL have two states: IDLE (VALID=0) and GRANT (VALID=1).
REQ-010 The block SHALL keep an internal 3-bit pointer LAST holding the most recently granted channel.
REQ-011 IDLE transition: IDLE with REQ!=0 SHALL go to GRANT next cycle, with S = first set REQ bit searching LAST+1, LAST+2, ... cyclically mod 5 (4 wraps to 0).
REQ-012 IDLE hold: IDLE with REQ==0 SHALL stay in IDLE, with S=3'b000 and VALID=0.
REQ-013 Grant hold: in GRANT with ACK=0, S and VALID SHALL be held stable even if REQ[S] drops.
REQ-014 Grant release: in GRANT with ACK=1, LAST SHALL load S; if any REQ bit other than bit S is set, the FSM SHALL stay in GRANT with S = next requester after the old S (back-to-back, no bubble); otherwise it SHALL go to IDLE.
REQ-015 Re-grant exclusion: the re-grant decision on ACK SHALL exclude bit S of REQ, so the same channel is never granted twice in a row while another channel is requesting; a lone requester is re-granted after one IDLE cycle.
REQ-016 ACK while VALID=0 SHALL be ignored.
REQ-017 Latency: grant latency SHALL be exactly 1 cycle from REQ sampled in IDLE to VALID=1.
REQ-018 REQ bits 5..7 do not exist; S SHALL never leave the range 0..4.

Reset
REQ-019 While RST=1, the block SHALL hold S=3'b000, VALID=0, TIMEOUT=0, state IDLE, LAST=3'd4 (so channel 0 wins first), and timeout counter 0, asynchronously.
REQ-020 Reset asserted mid-grant SHALL drop VALID immediately; the first post-reset grant SHALL follow REQ-011 with LAST=4.

Configuration
REQ-021 When macro MUX_SEL_TIMEOUT_EN is defined, a 4-bit counter SHALL clear on entry to GRANT and increment each GRANT cycle with ACK=0.
REQ-022 With MUX_SEL_TIMEOUT_EN defined, when the counter reaches TO_CYCLES-1 with ACK=0, the block SHALL pulse TIMEOUT for 1 cycle, load LAST with S, and re-arbitrate exactly as on ACK.
REQ-023 With MUX_SEL_TIMEOUT_EN defined, ACK on the same cycle as expiry SHALL take precedence, with no TIMEOUT pulse.
REQ-024 When MUX_SEL_TIMEOUT_EN is not defined, no counter and no TIMEOUT port SHALL exist, and a grant SHALL be held indefinitely until ACK.

Structure
REQ-025 Shared package/header mux_sel_pkg SHALL hold NUM_CH=5, SEL_W=3, the IDLE/GRANT state encodings, and the default TO_CYCLES.
REQ-026 The cyclic priority search SHALL be a combinational sub-module rr_pick5 (inputs: 5-bit request mask, 3-bit start pointer; outputs: 3-bit index, found flag), instantiated once.
REQ-027 S SHALL drive the downstream mux select directly, with no glue logic.

Verification
REQ-028 Reset release with REQ=5'b00000 -> VALID=0 and S=0 held for 10 cycles.
REQ-029 REQ=5'b11111 held, ACK=1 every cycle -> S sequence 0,1,2,3,4,0 on consecutive cycles with VALID continuously 1.
REQ-030 REQ=5'b00100, ACK pulsed on each grant -> S=2 grants alternate with 1-cycle IDLE gaps.
REQ-031 Grant S=3 with ACK=0 for 8 cycles while REQ drops to 5'b00001 -> S=3 and VALID=1 stable; ACK -> S=0 next cycle.
REQ-032 RST pulsed during GRANT S=4 -> VALID=0 immediately; after release with REQ=5'b10001 -> S=0 first.
REQ-033 With MUX_SEL_TIMEOUT_EN, TO_CYCLES=4, REQ=5'b00011, ACK=0 -> TIMEOUT pulses on the 4th GRANT cycle and S moves 0->1; ACK on the expiry cycle -> no TIMEOUT pulse.
